// File: rtl/gate_driver_pkg.sv
// Shared state encoding and counter widths for the gate-driver pulse block.
package gate_driver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StHoldoff,
    StFault
  } gate_state_e;

  localparam int unsigned WidthBitsDefault = 16;
  localparam int unsigned PulseCountBits   = 32;
  localparam int unsigned MissedCountBits  = 16;

  localparam logic [MissedCountBits-1:0] MissedCountMax = '1;

endpackage

// File: rtl/gate_driver_down_counter.sv
// Loadable down-counter; terminal is asserted on the last tick of a loaded interval.
module gate_driver_down_counter #(
  parameter int unsigned WIDTH_BITS = 16
) (
  input  logic                  evrClk,
  input  logic                  evrReset,
  input  logic                  load,
  input  logic [WIDTH_BITS-1:0] loadValue,
  input  logic                  enable,
  output logic                  terminal
);

  localparam logic [WIDTH_BITS-1:0] One = WIDTH_BITS'(1);

  logic [WIDTH_BITS-1:0] countQ;

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      countQ <= '0;
    end else if (load) begin
      countQ <= loadValue;
    end else if (enable && (countQ != '0)) begin
      countQ <= countQ - One;
    end
  end

  // A loaded value of N gives N enabled cycles; a zero count never stalls the caller.
  assign terminal = (countQ <= One);

endmodule

// File: rtl/gate_driver_pulse.sv
// Strobe-triggered gate-drive pulse with holdoff, fault latch and statistics.
// Optional pulse-length watchdog enabled by defining GATE_DRIVER_WATCHDOG_EN.
module gate_driver_pulse
  import gate_driver_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = WidthBitsDefault
`ifdef GATE_DRIVER_WATCHDOG_EN
  ,
  parameter int unsigned MAX_PULSE_TICKS = 10000
`endif
) (
  input  logic                       evrClk,
  input  logic                       evrReset,
  input  logic                       evrGateDriverStrobe,
  input  logic                       cfgEnable,
  input  logic [WIDTH_BITS-1:0]      cfgPulseWidth,
  input  logic [WIDTH_BITS-1:0]      cfgHoldoff,
  input  logic                       evrFault,
  input  logic                       evrFaultClear,
  output logic                       evrGateDrive,
  output logic                       evrBusy,
  output logic                       evrFaultLatched,
  output logic [PulseCountBits-1:0]  evrPulseCount,
`ifdef GATE_DRIVER_WATCHDOG_EN
  output logic                       evrWatchdogTrip,
`endif
  output logic [MissedCountBits-1:0] evrMissedCount
);

  gate_state_e stateQ, stateD;

  logic                       gateDriveQ;
  logic                       busyQ;
  logic                       faultLatchedQ;
  logic [PulseCountBits-1:0]  pulseCountQ;
  logic [MissedCountBits-1:0] missedCountQ;

  logic faultIn;
  logic pulseLoad, pulseTc;
  logic holdLoad, holdTc;
  logic acceptPulse;
  logic missedStrobe;
  logic faultExit;

  gate_driver_down_counter #(
    .WIDTH_BITS(WIDTH_BITS)
  ) u_pulse_counter (
    .evrClk   (evrClk),
    .evrReset (evrReset),
    .load     (pulseLoad),
    .loadValue(cfgPulseWidth),
    .enable   (stateQ == StPulse),
    .terminal (pulseTc)
  );

  gate_driver_down_counter #(
    .WIDTH_BITS(WIDTH_BITS)
  ) u_holdoff_counter (
    .evrClk   (evrClk),
    .evrReset (evrReset),
    .load     (holdLoad),
    .loadValue(cfgHoldoff),
    .enable   (stateQ == StHoldoff),
    .terminal (holdTc)
  );

`ifdef GATE_DRIVER_WATCHDOG_EN
  localparam int unsigned WdBits = $clog2(MAX_PULSE_TICKS + 1);

  logic [WdBits-1:0] wdCountQ;
  logic              wdTrip;
  logic              wdTripQ;

  // Counts completed high cycles of the registered output, independent of the FSM.
  always_ff @(posedge evrClk) begin
    if (evrReset || !gateDriveQ) begin
      wdCountQ <= '0;
    end else begin
      wdCountQ <= wdCountQ + WdBits'(1);
    end
  end

  assign wdTrip = gateDriveQ && (wdCountQ == WdBits'(MAX_PULSE_TICKS - 1));

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      wdTripQ <= 1'b0;
    end else if (wdTrip) begin
      wdTripQ <= 1'b1;
    end else if (faultExit) begin
      wdTripQ <= 1'b0;
    end
  end

  assign evrWatchdogTrip = wdTripQ;
  assign faultIn         = evrFault | wdTrip;
`else
  assign faultIn = evrFault;
`endif

  always_comb begin
    stateD       = stateQ;
    pulseLoad    = 1'b0;
    holdLoad     = 1'b0;
    acceptPulse  = 1'b0;
    missedStrobe = 1'b0;

    if (faultIn) begin
      // Fault wins over everything, including a coincident strobe.
      stateD       = StFault;
      missedStrobe = evrGateDriverStrobe;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (evrGateDriverStrobe) begin
            if (!cfgEnable) begin
              missedStrobe = 1'b1;
            end else if (cfgPulseWidth != '0) begin
              stateD      = StPulse;
              pulseLoad   = 1'b1;
              acceptPulse = 1'b1;
            end else if (cfgHoldoff != '0) begin
              // Zero-width trigger skips the pulse but still enforces re-arm holdoff.
              stateD   = StHoldoff;
              holdLoad = 1'b1;
            end
          end
        end
        StPulse: begin
          missedStrobe = evrGateDriverStrobe;
          if (pulseTc) begin
            holdLoad = 1'b1;
            stateD   = (cfgHoldoff != '0) ? StHoldoff : StIdle;
          end
        end
        StHoldoff: begin
          missedStrobe = evrGateDriverStrobe;
          if (holdTc) begin
            stateD = StIdle;
          end
        end
        StFault: begin
          missedStrobe = evrGateDriverStrobe;
          if (evrFaultClear) begin
            stateD = StIdle;
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  assign faultExit = (stateQ == StFault) && (stateD == StIdle);

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      stateQ        <= StIdle;
      gateDriveQ    <= 1'b0;
      busyQ         <= 1'b0;
      faultLatchedQ <= 1'b0;
      pulseCountQ   <= '0;
      missedCountQ  <= '0;
    end else begin
      stateQ     <= stateD;
      gateDriveQ <= (stateD == StPulse);
      busyQ      <= (stateD != StIdle);
      if (faultIn) begin
        faultLatchedQ <= 1'b1;
      end else if (faultExit) begin
        faultLatchedQ <= 1'b0;
      end
      if (acceptPulse) begin
        pulseCountQ <= pulseCountQ + PulseCountBits'(1);
      end
      if (missedStrobe && (missedCountQ != MissedCountMax)) begin
        missedCountQ <= missedCountQ + MissedCountBits'(1);
      end
    end
  end

  assign evrGateDrive    = gateDriveQ;
  assign evrBusy         = busyQ;
  assign evrFaultLatched = faultLatchedQ;
  assign evrPulseCount   = pulseCountQ;
  assign evrMissedCount  = missedCountQ;

endmodule

// File: tb/tb_gate_driver_pulse.sv
// Self-checking bench for gate_driver_pulse: vector table plus hand-written fault/reset sequences.
module tb_gate_driver_pulse;

  typedef struct packed {
    logic        gate;
    logic        busy;
    logic        latched;
    logic        wd;
    logic [31:0] pulse;
    logic [15:0] missed;
  } exp_t;

  typedef struct {
    logic        strobe;
    logic        enable;
    logic [15:0] width;
    logic [15:0] holdoff;
    int          reps;
    logic        gate;
    logic        busy;
    logic [31:0] pulse;
    logic [15:0] missed;
  } vec_t;

  logic        evrClk = 1'b0;
  logic        evrReset;
  logic        evrGateDriverStrobe;
  logic        cfgEnable;
  logic [15:0] cfgPulseWidth;
  logic [15:0] cfgHoldoff;
  logic        evrFault;
  logic        evrFaultClear;
  logic        evrGateDrive;
  logic        evrBusy;
  logic        evrFaultLatched;
  logic [31:0] evrPulseCount;
  logic [15:0] evrMissedCount;
  logic        wdTripObs;

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];
  vec_t vecs[$];

  always #5 evrClk = ~evrClk;

`ifdef GATE_DRIVER_WATCHDOG_EN
  logic evrWatchdogTrip;
  assign wdTripObs = evrWatchdogTrip;

  gate_driver_pulse #(
    .WIDTH_BITS     (16),
    .MAX_PULSE_TICKS(50)
  ) dut (
    .evrClk             (evrClk),
    .evrReset           (evrReset),
    .evrGateDriverStrobe(evrGateDriverStrobe),
    .cfgEnable          (cfgEnable),
    .cfgPulseWidth      (cfgPulseWidth),
    .cfgHoldoff         (cfgHoldoff),
    .evrFault           (evrFault),
    .evrFaultClear      (evrFaultClear),
    .evrGateDrive       (evrGateDrive),
    .evrBusy            (evrBusy),
    .evrFaultLatched    (evrFaultLatched),
    .evrPulseCount      (evrPulseCount),
    .evrWatchdogTrip    (evrWatchdogTrip),
    .evrMissedCount     (evrMissedCount)
  );
`else
  assign wdTripObs = 1'b0;

  gate_driver_pulse #(
    .WIDTH_BITS(16)
  ) dut (
    .evrClk             (evrClk),
    .evrReset           (evrReset),
    .evrGateDriverStrobe(evrGateDriverStrobe),
    .cfgEnable          (cfgEnable),
    .cfgPulseWidth      (cfgPulseWidth),
    .cfgHoldoff         (cfgHoldoff),
    .evrFault           (evrFault),
    .evrFaultClear      (evrFaultClear),
    .evrGateDrive       (evrGateDrive),
    .evrBusy            (evrBusy),
    .evrFaultLatched    (evrFaultLatched),
    .evrPulseCount      (evrPulseCount),
    .evrMissedCount     (evrMissedCount)
  );
`endif

  function automatic exp_t mk(input logic g, input logic b, input logic l, input logic w,
                              input logic [31:0] p, input logic [15:0] m);
    exp_t e;
    e.gate    = g;
    e.busy    = b;
    e.latched = l;
    e.wd      = w;
    e.pulse   = p;
    e.missed  = m;
    return e;
  endfunction

  // Expectation is queued with the stimulus and retired one edge later.
  task automatic tick(input exp_t e, input string name);
    exp_t got;
    exp_t want;
    expQ.push_back(e);
    @(posedge evrClk);
    #1;
    got.gate    = evrGateDrive;
    got.busy    = evrBusy;
    got.latched = evrFaultLatched;
    got.wd      = wdTripObs;
    got.pulse   = evrPulseCount;
    got.missed  = evrMissedCount;
    want = expQ.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got gate=%b busy=%b flt=%b wd=%b pulses=%0d missed=%0d, want gate=%b busy=%b flt=%b wd=%b pulses=%0d missed=%0d",
               name, $time, got.gate, got.busy, got.latched, got.wd, got.pulse, got.missed,
               want.gate, want.busy, want.latched, want.wd, want.pulse, want.missed);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, want completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    // strobe, enable, width, holdoff, reps, gate, busy, pulses, missed
    vecs.push_back('{1'b0, 1'b1, 16'd5, 16'd3, 10, 1'b0, 1'b0, 32'd0, 16'd0});
    vecs.push_back('{1'b1, 1'b1, 16'd5, 16'd3,  4, 1'b1, 1'b1, 32'd1, 16'd0});
    vecs.push_back('{1'b1, 1'b1, 16'd5, 16'd3,  1, 1'b1, 1'b1, 32'd1, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 16'd5, 16'd3,  3, 1'b0, 1'b1, 32'd1, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 16'd5, 16'd3,  2, 1'b0, 1'b0, 32'd1, 16'd1});
    vecs.push_back('{1'b1, 1'b1, 16'd5, 16'd3,  5, 1'b1, 1'b1, 32'd2, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 16'd5, 16'd3,  3, 1'b0, 1'b1, 32'd2, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 16'd5, 16'd3,  1, 1'b0, 1'b0, 32'd2, 16'd1});
    vecs.push_back('{1'b1, 1'b1, 16'd0, 16'd3,  3, 1'b0, 1'b1, 32'd2, 16'd1});
    vecs.push_back('{1'b0, 1'b1, 16'd0, 16'd3,  1, 1'b0, 1'b0, 32'd2, 16'd1});
    vecs.push_back('{1'b1, 1'b0, 16'd5, 16'd3,  1, 1'b0, 1'b0, 32'd2, 16'd2});
    vecs.push_back('{1'b1, 1'b0, 16'd5, 16'd3,  1, 1'b0, 1'b0, 32'd2, 16'd3});
    vecs.push_back('{1'b0, 1'b1, 16'd5, 16'd3,  1, 1'b0, 1'b0, 32'd2, 16'd3});
    vecs.push_back('{1'b1, 1'b1, 16'd2, 16'd0,  2, 1'b1, 1'b1, 32'd3, 16'd3});
    vecs.push_back('{1'b0, 1'b1, 16'd2, 16'd0,  1, 1'b0, 1'b0, 32'd3, 16'd3});
    vecs.push_back('{1'b1, 1'b1, 16'd2, 16'd0,  2, 1'b1, 1'b1, 32'd4, 16'd3});
    vecs.push_back('{1'b0, 1'b1, 16'd2, 16'd0,  1, 1'b0, 1'b0, 32'd4, 16'd3});

    evrReset            = 1'b1;
    evrGateDriverStrobe = 1'b0;
    cfgEnable           = 1'b1;
    cfgPulseWidth       = 16'd5;
    cfgHoldoff          = 16'd3;
    evrFault            = 1'b0;
    evrFaultClear       = 1'b0;
    tick(mk(0, 0, 0, 0, 0, 0), "reset");
    tick(mk(0, 0, 0, 0, 0, 0), "reset");
    evrReset = 1'b0;

    foreach (vecs[i]) begin
      cfgEnable     = vecs[i].enable;
      cfgPulseWidth = vecs[i].width;
      cfgHoldoff    = vecs[i].holdoff;
      for (int r = 0; r < vecs[i].reps; r++) begin
        evrGateDriverStrobe = (r == 0) ? vecs[i].strobe : 1'b0;
        tick(mk(vecs[i].gate, vecs[i].busy, 0, 0, vecs[i].pulse, vecs[i].missed), "vector");
      end
    end
    evrGateDriverStrobe = 1'b0;

    // Fault abort 30 cycles into a long pulse, blocked clear, then real clear.
    cfgPulseWidth       = 16'd100;
    cfgHoldoff          = 16'd3;
    evrGateDriverStrobe = 1'b1;
    tick(mk(1, 1, 0, 0, 5, 3), "long_pulse");
    evrGateDriverStrobe = 1'b0;
    repeat (29) tick(mk(1, 1, 0, 0, 5, 3), "long_pulse");
    evrFault = 1'b1;
    tick(mk(0, 1, 1, 0, 5, 3), "fault_abort");
    evrFaultClear = 1'b1;
    tick(mk(0, 1, 1, 0, 5, 3), "clear_while_fault");
    evrFaultClear       = 1'b0;
    evrFault            = 1'b0;
    evrGateDriverStrobe = 1'b1;
    tick(mk(0, 1, 1, 0, 5, 4), "strobe_in_fault");
    evrGateDriverStrobe = 1'b0;
    evrFaultClear       = 1'b1;
    tick(mk(0, 0, 0, 0, 5, 4), "fault_clear");
    evrFaultClear       = 1'b0;
    cfgPulseWidth       = 16'd5;
    evrGateDriverStrobe = 1'b1;
    tick(mk(1, 1, 0, 0, 6, 4), "pulse_after_clear");
    evrGateDriverStrobe = 1'b0;
    repeat (4) tick(mk(1, 1, 0, 0, 6, 4), "pulse_after_clear");
    repeat (3) tick(mk(0, 1, 0, 0, 6, 4), "holdoff_after_clear");
    tick(mk(0, 0, 0, 0, 6, 4), "idle_after_clear");

    // Strobe coincident with fault in IDLE is missed.
    evrFault            = 1'b1;
    evrGateDriverStrobe = 1'b1;
    tick(mk(0, 1, 1, 0, 6, 5), "fault_vs_strobe");
    evrFault            = 1'b0;
    evrGateDriverStrobe = 1'b0;
    evrFaultClear       = 1'b1;
    tick(mk(0, 0, 0, 0, 6, 5), "fault_clear2");
    evrFaultClear = 1'b0;

    // Reset mid-pulse.
    evrGateDriverStrobe = 1'b1;
    tick(mk(1, 1, 0, 0, 7, 5), "pre_reset_pulse");
    evrGateDriverStrobe = 1'b0;
    tick(mk(1, 1, 0, 0, 7, 5), "pre_reset_pulse");
    evrReset = 1'b1;
    tick(mk(0, 0, 0, 0, 0, 0), "reset_mid_pulse");
    evrReset = 1'b0;
    tick(mk(0, 0, 0, 0, 0, 0), "after_reset");

`ifdef GATE_DRIVER_WATCHDOG_EN
    cfgPulseWidth       = 16'd60;
    cfgHoldoff          = 16'd0;
    evrGateDriverStrobe = 1'b1;
    tick(mk(1, 1, 0, 0, 1, 0), "wd_pulse");
    evrGateDriverStrobe = 1'b0;
    repeat (49) tick(mk(1, 1, 0, 0, 1, 0), "wd_pulse");
    tick(mk(0, 1, 1, 1, 1, 0), "wd_trip");
    evrFaultClear = 1'b1;
    tick(mk(0, 0, 0, 0, 1, 0), "wd_clear");
    evrFaultClear = 1'b0;
`endif

    // Missed-count saturation: 70000 strobes while disabled.
    cfgEnable           = 1'b0;
    evrGateDriverStrobe = 1'b1;
    repeat (65534) @(posedge evrClk);
    tick(mk(0, 0, 0, 0, evrPulseCount, 16'hFFFF), "missed_reach_max");
    repeat (4464) @(posedge evrClk);
    tick(mk(0, 0, 0, 0, evrPulseCount, 16'hFFFF), "missed_saturate");
    evrGateDriverStrobe = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
